acc_cpu_core: RTL and testbench

- Parametrised accumulator CPU core; next generation of the 8-bit single-accumulator tile CPU.
- Adds configurable data width, a small general register file, ALU flags, shift/XOR/compare/load/store ops, an explicit instruction-valid handshake and a registered output port.
- Sits between the tile wrapper (which maps pins onto opcode/operand) and the output pins.
- Two-stage pipeline: capture into the instruction register, then execute.

---
 rtl/acc_cpu_pkg.sv | 27 ++
 rtl/acc_cpu_alu.sv | 101 ++++++++++
 rtl/acc_cpu_core.sv | 112 +++++++++++
 tb/tb_acc_cpu_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core.
// Contents: the 4-bit opcode encodings and the bit positions of the flags
// inside the {N, C, Z} flag vector.
package acc_cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ADDR = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_RSV  = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU core.
// Ports:
//   opcode     - instruction being executed
//   acc        - current accumulator value
//   src        - second operand (immediate, or register value for LD/ADDR)
//   c_in       - current carry flag; passed through when C is not updated
//   result     - new accumulator value (valid when wr_acc is high)
//   wr_acc     - accumulator write enable
//   flags_new  - candidate {N, C, Z}
//   flags_mask - per-flag update enable, same bit layout as flags_new
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] src,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              wr_acc,
  output logic [2:0]        flags_new,
  output logic [2:0]        flags_mask
);

  logic [DATA_W:0]   sum_s;
  logic [DATA_W:0]   diff_s;
  logic [DATA_W-1:0] zn_val_s;
  logic              c_s;
  logic              zn_upd_s;
  logic              c_upd_s;

  // The extra top bit is carry-out for the sum and borrow for the difference.
  assign sum_s  = {1'b0, acc} + {1'b0, src};
  assign diff_s = {1'b0, acc} - {1'b0, src};

  // Opcode decode: result, write enable and flag sources.
  always_comb begin
    result   = acc;
    wr_acc   = 1'b0;
    zn_val_s = acc;
    c_s      = c_in;
    zn_upd_s = 1'b0;
    c_upd_s  = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDR: begin
        result = sum_s[DATA_W-1:0];
        wr_acc = 1'b1;  zn_upd_s = 1'b1;  c_upd_s = 1'b1;
        c_s    = sum_s[DATA_W];
      end
      OP_SUB: begin
        result = diff_s[DATA_W-1:0];
        wr_acc = 1'b1;  zn_upd_s = 1'b1;  c_upd_s = 1'b1;
        c_s    = diff_s[DATA_W];
      end
      OP_AND: begin result = acc & src; wr_acc = 1'b1; zn_upd_s = 1'b1; end
      OP_OR:  begin result = acc | src; wr_acc = 1'b1; zn_upd_s = 1'b1; end
      OP_NOT: begin result = ~acc;      wr_acc = 1'b1; zn_upd_s = 1'b1; end
      OP_XOR: begin result = acc ^ src; wr_acc = 1'b1; zn_upd_s = 1'b1; end
      OP_SHL: begin
        result = {acc[DATA_W-2:0], 1'b0};
        wr_acc = 1'b1;  zn_upd_s = 1'b1;  c_upd_s = 1'b1;
        c_s    = acc[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, acc[DATA_W-1:1]};
        wr_acc = 1'b1;  zn_upd_s = 1'b1;  c_upd_s = 1'b1;
        c_s    = acc[0];
      end
      OP_LDI, OP_LD: begin result = src; wr_acc = 1'b1; zn_upd_s = 1'b1; end
      OP_CMP: begin
        // Flags as for SUB, but the accumulator is left alone.
        zn_val_s = diff_s[DATA_W-1:0];
        zn_upd_s = 1'b1;  c_upd_s = 1'b1;
        c_s      = diff_s[DATA_W];
      end
      default: begin
        // NOP, ST, OUT and the reserved opcode touch neither acc nor flags.
        result = acc;
      end
    endcase
    if (wr_acc) begin
      zn_val_s = result;
    end else begin
      zn_val_s = zn_val_s;
    end
  end

  // Assemble the {N, C, Z} candidates and their update masks.
  always_comb begin
    flags_new          = 3'b000;
    flags_mask         = 3'b000;
    flags_new[FLAG_Z]  = (zn_val_s == {DATA_W{1'b0}});
    flags_new[FLAG_C]  = c_s;
    flags_new[FLAG_N]  = zn_val_s[DATA_W-1];
    flags_mask[FLAG_Z] = zn_upd_s;
    flags_mask[FLAG_C] = c_upd_s;
    flags_mask[FLAG_N] = zn_upd_s;
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Two-stage accumulator CPU core: capture into the instruction register,
// then execute on the following enabled edge.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   ena                 - global enable; low freezes all state
//   instr_valid         - opcode/operand valid this cycle
//   opcode, operand     - instruction; operand is an immediate or register index
//   acc, flags          - accumulator and {N, C, Z}
//   out_data/out_strobe - registered output port and its one-cycle write pulse
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              instr_valid,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] acc,
  output logic [2:0]        flags,
  output logic [DATA_W-1:0] out_data,
  output logic              out_strobe
);

  localparam int IDX_W = $clog2(NREG);

  logic [3:0]        ir_op_r;
  logic [DATA_W-1:0] ir_operand_r;
  logic              ir_valid_r;
  logic [DATA_W-1:0] regs_r [NREG];
  logic [DATA_W-1:0] acc_r;
  logic [2:0]        flags_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_strobe_r;

  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] src_s;
  logic [DATA_W-1:0] result_s;
  logic              wr_acc_s;
  logic [2:0]        flags_new_s;
  logic [2:0]        flags_mask_s;

  // Upper operand bits are ignored, so out-of-range indices alias.
  assign idx_s = ir_operand_r[IDX_W-1:0];

  // LD and ADDR take the register value; every other op takes the immediate.
  always_comb begin
    if ((ir_op_r == OP_LD) || (ir_op_r == OP_ADDR)) begin
      src_s = regs_r[idx_s];
    end else begin
      src_s = ir_operand_r;
    end
  end

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode     (ir_op_r),
    .acc        (acc_r),
    .src        (src_s),
    .c_in       (flags_r[FLAG_C]),
    .result     (result_s),
    .wr_acc     (wr_acc_s),
    .flags_new  (flags_new_s),
    .flags_mask (flags_mask_s)
  );

  // Instruction capture, execute and output port state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_op_r      <= OP_NOP;
      ir_operand_r <= {DATA_W{1'b0}};
      ir_valid_r   <= 1'b0;
      acc_r        <= {DATA_W{1'b0}};
      flags_r      <= 3'b000;
      out_data_r   <= {DATA_W{1'b0}};
      out_strobe_r <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (ena) begin
      ir_valid_r <= instr_valid;
      if (instr_valid) begin
        ir_op_r      <= opcode;
        ir_operand_r <= operand;
      end
      out_strobe_r <= ir_valid_r && (ir_op_r == OP_OUT);
      if (ir_valid_r) begin
        if (wr_acc_s) begin
          acc_r <= result_s;
        end
        flags_r <= (flags_r & ~flags_mask_s) | (flags_new_s & flags_mask_s);
        if (ir_op_r == OP_ST) begin
          regs_r[idx_s] <= acc_r;
        end
        if (ir_op_r == OP_OUT) begin
          out_data_r <= acc_r;
        end
      end
    end else begin
      // Frozen: only the strobe drops so a held OUT is not re-signalled.
      out_strobe_r <= 1'b0;
    end
  end

  assign acc        = acc_r;
  assign flags      = flags_r;
  assign out_data   = out_data_r;
  assign out_strobe = out_strobe_r;

endmodule

// File: tb/tb_acc_cpu_core.sv
module tb_acc_cpu_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       instr_valid;
  logic [3:0] opcode;
  logic [7:0] operand;
  logic [7:0] acc;
  logic [2:0] flags;
  logic [7:0] out_data;
  logic       out_strobe;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Behavioural model state (integer arithmetic, DATA_W=8, NREG=4).
  int m_acc, m_out, m_n, m_c, m_z, m_strobe;
  int m_regs [4];
  int p_v, p_op, p_imm;

  acc_cpu_core #(.DATA_W(8), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .instr_valid(instr_valid),
    .opcode(opcode), .operand(operand), .acc(acc), .flags(flags),
    .out_data(out_data), .out_strobe(out_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_out = 0; m_n = 0; m_c = 0; m_z = 0; m_strobe = 0;
    p_v = 0; p_op = 0; p_imm = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
  endtask

  task automatic set_zn(input int v);
    m_z = (v == 0);
    m_n = (v >= 128);
  endtask

  task automatic model_exec(input int op, input int imm);
    int r;
    int rv;
    rv = m_regs[imm % 4];
    case (op)
      1:  begin r = m_acc + imm; m_c = (r > 255); m_acc = r % 256; set_zn(m_acc); end
      2:  begin m_c = (imm > m_acc); m_acc = (m_acc - imm + 256) % 256; set_zn(m_acc); end
      3:  begin m_acc = m_acc & imm; set_zn(m_acc); end
      4:  begin m_acc = m_acc | imm; set_zn(m_acc); end
      5:  begin m_acc = 255 - m_acc; set_zn(m_acc); end
      6:  begin m_acc = m_acc ^ imm; set_zn(m_acc); end
      7:  begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; set_zn(m_acc); end
      8:  begin m_c = m_acc % 2; m_acc = m_acc / 2; set_zn(m_acc); end
      9:  begin m_acc = imm; set_zn(m_acc); end
      10: m_regs[imm % 4] = m_acc;
      11: begin m_acc = rv; set_zn(m_acc); end
      12: begin r = m_acc + rv; m_c = (r > 255); m_acc = r % 256; set_zn(m_acc); end
      13: begin m_c = (imm > m_acc); set_zn((m_acc - imm + 256) % 256); end
      14: begin m_out = m_acc; m_strobe = 1; end
      default: ;
    endcase
  endtask

  // One clock of stimulus: called at negedge+1, returns at the next negedge+1.
  task automatic step(input bit e, input bit v, input logic [3:0] op, input logic [7:0] imm);
    ena = e; instr_valid = v; opcode = op; operand = imm;
    if (e) begin
      m_strobe = 0;
      if (p_v != 0) model_exec(p_op, p_imm);
      p_v = v; p_op = int'(op); p_imm = int'(imm);
    end else begin
      m_strobe = 0;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      check("acc", int'(acc), m_acc);
      check("flags", int'(flags), m_n * 4 + m_c * 2 + m_z);
      check("out_data", int'(out_data), m_out);
      check("out_strobe", int'(out_strobe), m_strobe);
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; instr_valid = 1'b0; opcode = 4'h0; operand = 8'h00;
    model_reset();
    @(negedge clk); @(negedge clk); #1;
    check("rst_acc", int'(acc), 0);
    check("rst_flags", int'(flags), 0);
    check("rst_out", int'(out_data), 0);
    check("rst_strobe", int'(out_strobe), 0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // LDI F0, ADD 20 back-to-back: carry out, wrap to 0x10.
    step(1'b1, 1'b1, 4'h9, 8'hF0);
    step(1'b1, 1'b1, 4'h1, 8'h20);
    check("ldi_f0", int'(acc), 8'hF0);
    step(1'b1, 1'b0, 4'h0, 8'h00);
    check("add_wrap_acc", int'(acc), 8'h10);
    check("add_wrap_flags", int'(flags), 3'b010);

    // LDI 05, SUB 06, SHR.
    step(1'b1, 1'b1, 4'h9, 8'h05);
    step(1'b1, 1'b1, 4'h2, 8'h06);
    step(1'b1, 1'b1, 4'h8, 8'h00);
    check("sub_acc", int'(acc), 8'hFF);
    check("sub_flags", int'(flags), 3'b110);
    step(1'b1, 1'b0, 4'h0, 8'h00);
    check("shr_acc", int'(acc), 8'h7F);
    check("shr_flags", int'(flags), 3'b010);

    // Register file with index aliasing.
    step(1'b1, 1'b1, 4'h9, 8'h3C);
    step(1'b1, 1'b1, 4'hA, 8'h02);
    step(1'b1, 1'b1, 4'h9, 8'h00);
    step(1'b1, 1'b1, 4'hB, 8'h06);
    check("ldi0_z", int'(flags[0]), 1);
    step(1'b1, 1'b1, 4'hC, 8'h02);
    check("ld_alias_acc", int'(acc), 8'h3C);
    check("ld_alias_z", int'(flags[0]), 0);
    step(1'b1, 1'b0, 4'h0, 8'h00);
    check("addr_acc", int'(acc), 8'h78);
    check("addr_c", int'(flags[1]), 0);

    // CMP equal and CMP less-than.
    step(1'b1, 1'b1, 4'h9, 8'h3C);
    step(1'b1, 1'b1, 4'hD, 8'h3C);
    step(1'b1, 1'b1, 4'hD, 8'h40);
    check("cmp_eq_acc", int'(acc), 8'h3C);
    check("cmp_eq_flags", int'(flags), 3'b001);
    step(1'b1, 1'b0, 4'h0, 8'h00);
    check("cmp_lt_acc", int'(acc), 8'h3C);
    check("cmp_lt_flags", int'(flags), 3'b110);

    // Enable freeze with a pending ADD, then OUT.
    step(1'b1, 1'b1, 4'h1, 8'h01);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h9, 8'h99);
    check("freeze_acc", int'(acc), 8'h3C);
    check("freeze_flags", int'(flags), 3'b110);
    step(1'b1, 1'b1, 4'hE, 8'h00);
    check("thaw_acc", int'(acc), 8'h3D);
    check("thaw_flags", int'(flags), 3'b000);
    step(1'b1, 1'b0, 4'h0, 8'h00);
    check("out_data_lit", int'(out_data), 8'h3D);
    check("out_strobe_hi", int'(out_strobe), 1);
    step(1'b1, 1'b0, 4'h0, 8'h00);
    check("out_strobe_lo", int'(out_strobe), 0);

    // Logic/shift ops and reserved opcodes, checked by the model.
    step(1'b1, 1'b1, 4'h9, 8'h81);
    step(1'b1, 1'b1, 4'h7, 8'h00);
    step(1'b1, 1'b1, 4'h6, 8'hFF);
    step(1'b1, 1'b1, 4'h3, 8'h0F);
    step(1'b1, 1'b1, 4'h4, 8'h30);
    step(1'b1, 1'b1, 4'h5, 8'h00);
    step(1'b1, 1'b1, 4'hF, 8'h12);
    step(1'b1, 1'b1, 4'hA, 8'h07);
    step(1'b1, 1'b1, 4'h9, 8'h00);
    step(1'b1, 1'b1, 4'hB, 8'h03);
    step(1'b1, 1'b0, 4'h0, 8'h00);
    check("logic_chain_acc", int'(acc), 8'hC2);

    // Reset between capture and execute discards the instruction.
    step(1'b1, 1'b1, 4'h9, 8'hAA);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_acc", int'(acc), 0);
    ena = 1'b1; instr_valid = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'h0, 8'h00);
    check("post_rst_acc", int'(acc), 0);
    step(1'b1, 1'b1, 4'h9, 8'h55);
    step(1'b1, 1'b0, 4'h0, 8'h00);
    check("post_rst_ldi", int'(acc), 8'h55);
    check("post_rst_flags", int'(flags), 3'b000);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
